// File: rtl/uart_rx_frontend_if.sv
// Serial line plus received-byte status bundle between the UART receive
// stage and its neighbours.
interface uart_rx_frontend_if;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    output UART_RX,
    input  rx_data, rx_int, rx_valid, frame_err
  );

  modport slave (
    input  UART_RX,
    output rx_data, rx_int, rx_valid, frame_err
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 16x oversampling, start-bit validation, 8 data
// bits LSB-first, early stop-bit decision, byte held on rx_data.
module uart_rx_frontend #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input logic              clk,
  input logic              rst,
  uart_rx_frontend_if.slave bus
);
  localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            rx_m_q, rx_s_q, rx_s_d_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      idx_q, idx_d;
  logic            samp7_q, samp7_d, samp8_q, samp8_d;
  logic            bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            int_q, int_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            tick;
  logic            maj;

  // Tick only runs outside IDLE so its phase starts at the detected edge.
  assign tick = (state_q != IDLE) && (cnt_q == CW'(DIV - 1));
  // Majority of the s=7,8 samples and the live s=9 sample.
  assign maj  = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_s_d_q <= 1'b1;
    end else begin
      rx_m_q   <= bus.UART_RX;
      rx_s_q   <= rx_m_q;
      rx_s_d_q <= rx_s_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      samp7_q <= 1'b0;
      samp8_q <= 1'b0;
      bit_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      int_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      samp7_q <= samp7_d;
      samp8_q <= samp8_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      int_q   <= int_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and output logic; bit value latched at s=9, consumed at s=15.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    idx_d   = idx_q;
    samp7_d = samp7_q;
    samp8_d = samp8_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    int_d   = int_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
      s_d   = '0;
      idx_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        s_d = s_q + 4'd1;
        if (s_q == 4'd7) samp7_d = rx_s_q;
        if (s_q == 4'd8) samp8_d = rx_s_q;
        if (s_q == 4'd9) bit_d   = maj;
      end
    end

    case (state_q)
      IDLE: begin
        if (rx_s_d_q && !rx_s_q) begin
          state_d = START;
          int_d   = 1'b1;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (tick && s_q == 4'd15) begin
          if (bit_q) begin
            state_d = IDLE;
            int_d   = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick && s_q == 4'd15) begin
          shift_d = {bit_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && s_q == 4'd9) begin
          data_d  = shift_q;
          ferr_d  = ~maj;
          int_d   = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_int    = int_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed and randomized frames against a frame-level reference model.
module tb_uart_rx_frontend;
  localparam int BIT_CLK = 160;
  // Start edge to rx_valid: 9 bits + 10 ticks + 3 synchronizer/register clocks.
  localparam longint LAT = 9 * 160 + 10 * 10 + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;
  int vectors = 0;
  int errors  = 0;

  uart_rx_frontend_if bus ();

  uart_rx_frontend #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    longint     t;
  } ev_t;

  ev_t    evq[$];
  ev_t    expq[$];
  longint riseq[$];
  longint exp_rise[$];
  int     bad_valid = 0;
  logic   prev_int = 1'b0;
  logic   prev_valid = 1'b0;

  // Passive monitor: records rx_valid events and rx_int rises.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      evq.push_back('{d: bus.rx_data, fe: bus.frame_err, t: cyc});
      if (!(prev_int && !bus.rx_int)) bad_valid++;
      if (prev_valid) bad_valid++;
    end
    if (bus.rx_int && !prev_int) riseq.push_back(cyc);
    prev_int   = bus.rx_int;
    prev_valid = bus.rx_valid;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    expq.push_back('{d: b, fe: ~stopb, t: cyc});
    exp_rise.push_back(cyc);
    bus.UART_RX = 1'b0;
    clk_n(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      bus.UART_RX = b[i];
      clk_n(BIT_CLK);
    end
    bus.UART_RX = stopb;
    clk_n(BIT_CLK);
    bus.UART_RX = 1'b1;
  endtask

  task automatic check_frames(input string tag);
    longint dt;
    int n;
    chk({tag, "_nframes"}, evq.size(), expq.size());
    n = (evq.size() < expq.size()) ? evq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, evq[i].d, expq[i].d);
      chk({tag, "_ferr"}, evq[i].fe, expq[i].fe);
      dt = evq[i].t - expq[i].t;
      chk({tag, "_lat_ok"}, (dt >= LAT - 10 && dt <= LAT + 10) ? 1 : 0, 1);
    end
    chk({tag, "_nrises"}, riseq.size(), exp_rise.size());
    n = (riseq.size() < exp_rise.size()) ? riseq.size() : exp_rise.size();
    for (int i = 0; i < n; i++) chk({tag, "_rise_dly"}, riseq[i] - exp_rise[i], 3);
    chk({tag, "_valid_shape"}, bad_valid, 0);
    evq.delete(); expq.delete(); riseq.delete(); exp_rise.delete();
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] held;
    bus.UART_RX = 1'b1;
    rst = 1'b1;
    clk_n(5);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_int", bus.rx_int, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_ferr", bus.frame_err, 0);
    rst = 1'b0;
    clk_n(2000);
    chk("idle_frames", evq.size(), 0);
    chk("idle_rises", riseq.size(), 0);
    chk("idle_int", bus.rx_int, 0);

    // Single byte
    send_frame(8'hA5, 1'b1);
    clk_n(300);
    check_frames("single");
    chk("single_hold", bus.rx_data, 8'hA5);

    // Glitch: short low pulse must be rejected at the start decision
    held = bus.rx_data;
    exp_rise.push_back(cyc);
    bus.UART_RX = 1'b0;
    clk_n(40);
    bus.UART_RX = 1'b1;
    clk_n(400);
    chk("glitch_int", bus.rx_int, 0);
    chk("glitch_data", bus.rx_data, held);
    chk("glitch_nframes", evq.size(), 0);
    chk("glitch_nrises", riseq.size(), exp_rise.size());
    evq.delete(); riseq.delete(); exp_rise.delete();

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0);
    clk_n(200);
    chk("ferr_level", bus.frame_err, 1);
    chk("ferr_data", bus.rx_data, 8'h3C);
    send_frame(8'h55, 1'b1);
    clk_n(300);
    check_frames("ferr");
    chk("ferr_clear", bus.frame_err, 0);

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    clk_n(300);
    check_frames("b2b");

    // Randomized bytes with random idle gaps
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1);
      clk_n($urandom_range(0, 50));
    end
    clk_n(300);
    check_frames("rand");

    // Reset during data bit 4 of 0x5A aborts immediately
    rb = 8'h5A;
    bus.UART_RX = 1'b0;
    clk_n(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      bus.UART_RX = rb[i];
      clk_n(BIT_CLK);
    end
    bus.UART_RX = rb[4];
    clk_n(80);
    chk("pre_abort_int", bus.rx_int, 1);
    rst = 1'b1;
    #1;
    chk("abort_data", bus.rx_data, 8'h00);
    chk("abort_int", bus.rx_int, 0);
    chk("abort_valid", bus.rx_valid, 0);
    chk("abort_ferr", bus.frame_err, 0);
    clk_n(3);
    bus.UART_RX = 1'b1;
    rst = 1'b0;
    clk_n(400);
    chk("abort_nframes", evq.size(), 0);
    evq.delete(); riseq.delete(); exp_rise.delete();
    send_frame(8'h5A, 1'b1);
    clk_n(300);
    check_frames("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
